// File: rtl/tri_side_sqrt_if.sv
// Handshake and data bundle for the triangle side square-root stage.
// Carries the squared-length request (valid/ready) and the root result (valid/ready).
// Ports: in_valid/in_ready/sq_* upstream side; out_valid/out_ready/side_*/side_exact/busy downstream side.
interface tri_side_sqrt_if #(
    parameter int SQ_W = 16
);
    localparam int RT_W = SQ_W / 2;

    logic            in_valid;
    logic            in_ready;
    logic [SQ_W-1:0] sq_ab;
    logic [SQ_W-1:0] sq_bc;
    logic [SQ_W-1:0] sq_ca;
    logic            out_valid;
    logic            out_ready;
    logic [RT_W-1:0] side_ab;
    logic [RT_W-1:0] side_bc;
    logic [RT_W-1:0] side_ca;
    logic [2:0]      side_exact;
    logic            busy;

    // Producer of squared lengths / consumer of roots.
    modport master (
        output in_valid, sq_ab, sq_bc, sq_ca, out_ready,
        input  in_ready, out_valid, side_ab, side_bc, side_ca, side_exact, busy
    );

    // The root engine itself.
    modport slave (
        input  in_valid, sq_ab, sq_bc, sq_ca, out_ready,
        output in_ready, out_valid, side_ab, side_bc, side_ca, side_exact, busy
    );
endinterface

// File: rtl/tri_side_sqrt.sv
// Floor square root of three squared side lengths on one shared bit-serial engine.
// Latency 3*RT_W cycles from accept to out_valid; initiation interval 3*RT_W+2.
// Backpressure: results held in DONE until out_ready; in_ready low outside IDLE.
// Ports: clk, rst_n (async active-low), bus (tri_side_sqrt_if.slave).
module tri_side_sqrt #(
    parameter int SQ_W = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    tri_side_sqrt_if.slave bus
);
    localparam int RT_W = SQ_W / 2;
    localparam int IT_W = (RT_W > 2) ? $clog2(RT_W) : 1;
    localparam logic [IT_W-1:0] ITER_LAST = IT_W'(RT_W - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [IT_W-1:0] iter_q, iter_d;
    logic [RT_W+1:0] rem_q, rem_d;
    logic [RT_W-1:0] root_q, root_d;
    logic [SQ_W-1:0] rad_q, rad_d;
    logic [SQ_W-1:0] hold_bc_q, hold_bc_d;
    logic [SQ_W-1:0] hold_ca_q, hold_ca_d;
    logic [RT_W-1:0] side_ab_q, side_ab_d;
    logic [RT_W-1:0] side_bc_q, side_bc_d;
    logic [RT_W-1:0] side_ca_q, side_ca_d;
    logic [2:0]      exact_q, exact_d;

    // One restoring-root step. The top two bits of rem_q are always zero
    // before the shift (rem <= 2*root with a partial root), so dropping them
    // keeps the shifted remainder within RT_W+2 bits without loss.
    logic [RT_W+1:0] rem_sh;
    logic [RT_W+1:0] trial;
    logic            take;
    logic [RT_W+1:0] rem_nx;
    logic [RT_W-1:0] root_nx;

    always_comb begin
        rem_sh  = {rem_q[RT_W-1:0], rad_q[SQ_W-1 -: 2]};
        trial   = {root_q, 2'b01};
        take    = (rem_sh >= trial);
        rem_nx  = take ? (rem_sh - trial) : rem_sh;
        root_nx = {root_q[RT_W-2:0], take};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            iter_q    <= '0;
            rem_q     <= '0;
            root_q    <= '0;
            rad_q     <= '0;
            hold_bc_q <= '0;
            hold_ca_q <= '0;
            side_ab_q <= '0;
            side_bc_q <= '0;
            side_ca_q <= '0;
            exact_q   <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            iter_q    <= iter_d;
            rem_q     <= rem_d;
            root_q    <= root_d;
            rad_q     <= rad_d;
            hold_bc_q <= hold_bc_d;
            hold_ca_q <= hold_ca_d;
            side_ab_q <= side_ab_d;
            side_bc_q <= side_bc_d;
            side_ca_q <= side_ca_d;
            exact_q   <= exact_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        iter_d    = iter_q;
        rem_d     = rem_q;
        root_d    = root_q;
        rad_d     = rad_q;
        hold_bc_d = hold_bc_q;
        hold_ca_d = hold_ca_q;
        side_ab_d = side_ab_q;
        side_bc_d = side_bc_q;
        side_ca_d = side_ca_q;
        exact_d   = exact_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    rad_d     = bus.sq_ab;
                    hold_bc_d = bus.sq_bc;
                    hold_ca_d = bus.sq_ca;
                    idx_d     = '0;
                    iter_d    = '0;
                    rem_d     = '0;
                    root_d    = '0;
                    state_d   = CALC;
                end
            end
            CALC: begin
                rad_d  = {rad_q[SQ_W-3:0], 2'b00};
                rem_d  = rem_nx;
                root_d = root_nx;
                iter_d = iter_q + 1'b1;
                if (iter_q == ITER_LAST) begin
                    // Radicand finished: commit its root and move to the next one.
                    case (idx_q)
                        2'd0: begin
                            side_ab_d  = root_nx;
                            exact_d[0] = (rem_nx == '0);
                            rad_d      = hold_bc_q;
                        end
                        2'd1: begin
                            side_bc_d  = root_nx;
                            exact_d[1] = (rem_nx == '0);
                            rad_d      = hold_ca_q;
                        end
                        default: begin
                            side_ca_d  = root_nx;
                            exact_d[2] = (rem_nx == '0);
                            state_d    = DONE;
                        end
                    endcase
                    rem_d  = '0;
                    root_d = '0;
                    iter_d = '0;
                    idx_d  = idx_q + 2'd1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decode the registered state only.
    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_valid  = (state_q == DONE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.side_ab    = side_ab_q;
    assign bus.side_bc    = side_bc_q;
    assign bus.side_ca    = side_ca_q;
    assign bus.side_exact = exact_q;
endmodule

// File: tb/tb_tri_side_sqrt.sv
// Self-checking bench for tri_side_sqrt: directed cases plus randomized triples
// against an arithmetic floor-sqrt reference.
// Inputs driven and outputs sampled 1 time unit after each rising edge.
module tb_tri_side_sqrt;
    localparam int SQ_W = 16;
    localparam int RT_W = SQ_W / 2;
    localparam int LAT  = 3 * RT_W;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    tri_side_sqrt_if #(.SQ_W(SQ_W)) bus ();

    tri_side_sqrt #(.SQ_W(SQ_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference: largest r with r*r <= x, found by plain counting.
    function automatic int unsigned isqrt(input int unsigned x);
        int unsigned r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    function automatic logic [2:0] exact_ref(input int unsigned a, input int unsigned b, input int unsigned c);
        logic [2:0] e;
        e[0] = (isqrt(a) * isqrt(a) == a);
        e[1] = (isqrt(b) * isqrt(b) == b);
        e[2] = (isqrt(c) * isqrt(c) == c);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_result(input string tag, input int unsigned a, input int unsigned b, input int unsigned c);
        chk({tag, "_ab"}, 32'(bus.side_ab), isqrt(a));
        chk({tag, "_bc"}, 32'(bus.side_bc), isqrt(b));
        chk({tag, "_ca"}, 32'(bus.side_ca), isqrt(c));
        chk({tag, "_exact"}, 32'(bus.side_exact), 32'(exact_ref(a, b, c)));
    endtask

    // Accept one triangle and wait for out_valid; returns cycles from accept edge.
    task automatic send(input logic [SQ_W-1:0] a, input logic [SQ_W-1:0] b, input logic [SQ_W-1:0] c,
                        output int lat);
        bus.sq_ab    = a;
        bus.sq_bc    = b;
        bus.sq_ca    = c;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic take();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic directed(input string tag, input logic [SQ_W-1:0] a, input logic [SQ_W-1:0] b,
                            input logic [SQ_W-1:0] c);
        int lat;
        send(a, b, c, lat);
        chk({tag, "_latency"}, lat, LAT);
        chk_result(tag, a, b, c);
        take();
        chk({tag, "_idle_rdy"}, 32'(bus.in_ready), 1);
    endtask

    initial begin
        int lat;
        logic [RT_W-1:0] h_ab, h_bc, h_ca;
        logic [2:0]      h_ex;
        int acc_edge[2];
        int acc_n, out_n, edge_n;
        logic [SQ_W-1:0] ra, rb, rc;

        n_chk = 0;
        n_fail = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.sq_ab = '0;
        bus.sq_bc = '0;
        bus.sq_ca = '0;
        #12;
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_side_ab", 32'(bus.side_ab), 0);
        chk("rst_exact", 32'(bus.side_exact), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Pythagorean triple, plus busy during CALC.
        bus.sq_ab = 16'd25; bus.sq_bc = 16'd144; bus.sq_ca = 16'd169;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("pyth_busy", 32'(bus.busy), 1);
        chk("pyth_in_ready_calc", 32'(bus.in_ready), 0);
        lat = 0;
        while (!bus.out_valid && lat < 200) begin
            tick();
            lat++;
        end
        chk("pyth_latency", lat, LAT);
        chk("pyth_ab", 32'(bus.side_ab), 5);
        chk("pyth_bc", 32'(bus.side_bc), 12);
        chk("pyth_ca", 32'(bus.side_ca), 13);
        chk("pyth_exact", 32'(bus.side_exact), 32'b111);
        take();

        // Extremes.
        directed("ext1", 16'd32768, 16'd0, 16'd1);
        directed("ext2", 16'hFFFF, 16'hFFFF, 16'hFFFF);

        // Backpressure: results and handshake frozen while out_ready is low.
        send(16'd49, 16'd50, 16'd81, lat);
        chk("bp_latency", lat, LAT);
        h_ab = bus.side_ab; h_bc = bus.side_bc; h_ca = bus.side_ca; h_ex = bus.side_exact;
        chk_result("bp", 49, 50, 81);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'($urandom);
            bus.sq_ab = 16'($urandom);
            bus.sq_bc = 16'($urandom);
            bus.sq_ca = 16'($urandom);
            tick();
            chk("bp_hold_valid", 32'(bus.out_valid), 1);
            chk("bp_in_ready", 32'(bus.in_ready), 0);
            chk("bp_hold_ab", 32'(bus.side_ab), 32'(h_ab));
            chk("bp_hold_bc", 32'(bus.side_bc), 32'(h_bc));
            chk("bp_hold_ca", 32'(bus.side_ca), 32'(h_ca));
            chk("bp_hold_exact", 32'(bus.side_exact), 32'(h_ex));
        end
        bus.in_valid = 1'b0;
        take();
        chk("bp_after_valid", 32'(bus.out_valid), 0);
        tick();
        chk("bp_no_second_accept", 32'(bus.busy), 0);

        // Back-to-back with in_valid and out_ready held high.
        bus.sq_ab = 16'd4; bus.sq_bc = 16'd9; bus.sq_ca = 16'd16;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        acc_n = 0; out_n = 0; edge_n = 0;
        acc_edge[0] = 0; acc_edge[1] = 0;
        while (out_n < 2 && edge_n < 200) begin
            if (bus.in_ready && bus.in_valid && acc_n < 2) begin
                acc_edge[acc_n] = edge_n;
                acc_n++;
            end
            if (bus.out_valid) begin
                if (out_n == 0) chk_result("b2b_first", 4, 9, 16);
                else            chk_result("b2b_second", 2, 3, 8);
                out_n++;
            end
            tick();
            edge_n++;
            if (acc_n == 1) begin
                bus.sq_ab = 16'd2; bus.sq_bc = 16'd3; bus.sq_ca = 16'd8;
            end
            if (acc_n == 2) bus.in_valid = 1'b0;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        chk("b2b_outputs", out_n, 2);
        chk("b2b_interval", acc_edge[1] - acc_edge[0], LAT + 2);
        tick();

        // Reset in the middle of CALC.
        bus.sq_ab = 16'd200; bus.sq_bc = 16'd300; bus.sq_ca = 16'd400;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        chk("mrst_in_ready", 32'(bus.in_ready), 1);
        chk("mrst_out_valid", 32'(bus.out_valid), 0);
        chk("mrst_busy", 32'(bus.busy), 0);
        chk("mrst_ab", 32'(bus.side_ab), 0);
        chk("mrst_bc", 32'(bus.side_bc), 0);
        chk("mrst_ca", 32'(bus.side_ca), 0);
        chk("mrst_exact", 32'(bus.side_exact), 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("mrst_no_output", 32'(bus.out_valid), 0);
        directed("post_rst", 16'd100, 16'd50, 16'd0);

        // Randomized triples with random downstream stall.
        for (int n = 0; n < 1000; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 16'($urandom);
            if (n % 50 == 0) rb = 16'(isqrt(32'(ra)) * isqrt(32'(ra)));
            send(ra, rb, rc, lat);
            chk("rnd_latency", lat, LAT);
            repeat ($urandom_range(0, 2)) tick();
            chk_result("rnd", ra, rb, rc);
            take();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
